// File: rtl/npu_pkg.sv
// Shared NPU definitions: SRAM destination indices, load-sequencer state
// encoding and error codes.
package npu_pkg;

  // Destination SRAM indices carried on the input stage write path.
  localparam logic [2:0] GEMM0_SRAM_IDX = 3'd0;  // image operand
  localparam logic [2:0] GEMM1_SRAM_IDX = 3'd1;  // kernel operand

  // Load sequencer states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_IMG = 3'd1,
    LOAD_KER = 3'd2,
    CHECK    = 3'd3,
    START    = 3'd4,
    RUN      = 3'd5,
    DONE     = 3'd6,
    ERR      = 3'd7
  } state_t;

  // Error causes reported on err_code.
  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_IMG_SIZE = 3'd1,
    ERR_KER_SIZE = 3'd2,
    ERR_SHAPE    = 3'd3,
    ERR_TIMEOUT  = 3'd4,
    ERR_ORDER    = 3'd5
  } err_code_t;

endpackage

// File: rtl/seg_counter.sv
// Saturating segment element counter with synchronous clear.
// A clear and an increment in the same cycle load the value 1, so the first
// element of a new segment can restart the count in one step.
module seg_counter #(
  parameter int WIDTH = 33
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: optional clear, then increment unless already all-ones.
  always_comb begin
    // NOTE: every combinational output gets a value before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    count_d = clr_i ? '0 : count_q;
    if (inc_i && !(&count_d)) begin
      count_d = count_d + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/gemm_load_sequencer.sv
// Sequences one GEMM job: tracks the image then kernel segment written into
// the GEMM0/GEMM1 SRAMs, validates the element counts and inner dimension,
// pulses compute_start, waits for compute_done and holds off the input stage
// while the job is checked and running.
// Optional build macro GEMM_LOAD_TIMEOUT_EN adds a RUN watchdog of
// TIMEOUT_CYCLES cycles (error code 4); without it RUN waits indefinitely.
module gemm_load_sequencer
  import npu_pkg::*;
#(
  parameter int ADDR_WIDTH         = 13,
  parameter int NUM_CHANNELS_WIDTH = 7,
  parameter int CNT_WIDTH          = 2*ADDR_WIDTH + NUM_CHANNELS_WIDTH
`ifdef GEMM_LOAD_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES     = 65536
`endif
) (
  input  logic                          s_axis_aclk,
  input  logic                          s_axis_areset,
  input  logic                          wr_valid,
  input  logic [2:0]                    wr_type,
  input  logic                          wr_last,
  input  logic [ADDR_WIDTH-1:0]         img_row,
  input  logic [ADDR_WIDTH-1:0]         img_col,
  input  logic [ADDR_WIDTH-1:0]         ker_row,
  input  logic [ADDR_WIDTH-1:0]         ker_col,
  input  logic [NUM_CHANNELS_WIDTH-1:0] num_channels,
  output logic                          in_ready,
  output logic                          compute_start,
  input  logic                          compute_done,
  output logic                          job_done,
  output logic                          busy,
  output logic                          err,
  output logic [2:0]                    err_code,
  input  logic                          clear_err
);

  state_t    state_q, state_d;
  err_code_t err_code_q, err_code_d;

  logic in_ready_q, compute_start_q, job_done_q, busy_q, err_q;

  logic [ADDR_WIDTH-1:0]         img_row_q, img_col_q, ker_row_q, ker_col_q;
  logic [NUM_CHANNELS_WIDTH-1:0] num_ch_q;

  logic                 img_clr, img_inc, ker_clr, ker_inc;
  logic                 cap_img, cap_ker;
  logic [CNT_WIDTH-1:0] img_cnt, ker_cnt;
  logic [CNT_WIDTH-1:0] img_size, ker_size;
  logic                 accept;

  // Only elements offered while in_ready is high belong to the job.
  assign accept = wr_valid && in_ready_q;

  // Expected segment sizes, widened before multiplying so nothing truncates.
  assign img_size = CNT_WIDTH'(img_row_q) * CNT_WIDTH'(img_col_q) * CNT_WIDTH'(num_ch_q);
  assign ker_size = CNT_WIDTH'(ker_row_q) * CNT_WIDTH'(ker_col_q) * CNT_WIDTH'(num_ch_q);

  seg_counter #(.WIDTH(CNT_WIDTH)) u_img_cnt (
    .clk_i   (s_axis_aclk),
    .rst_i   (s_axis_areset),
    .clr_i   (img_clr),
    .inc_i   (img_inc),
    .count_o (img_cnt)
  );

  seg_counter #(.WIDTH(CNT_WIDTH)) u_ker_cnt (
    .clk_i   (s_axis_aclk),
    .rst_i   (s_axis_areset),
    .clr_i   (ker_clr),
    .inc_i   (ker_inc),
    .count_o (ker_cnt)
  );

`ifdef GEMM_LOAD_TIMEOUT_EN
  localparam int RUN_CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  logic [RUN_CNT_WIDTH-1:0] run_cnt_q;
  logic                     run_limit;

  // Cycles already spent in RUN; the current RUN cycle is run_cnt_q + 1.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      run_cnt_q <= '0;
    end else if (state_q != RUN) begin
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_q + RUN_CNT_WIDTH'(1);
    end
  end

  assign run_limit = (run_cnt_q == RUN_CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`endif

  // Next-state, counter control and error-code selection.
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    img_clr    = 1'b0;
    img_inc    = 1'b0;
    ker_clr    = 1'b0;
    ker_inc    = 1'b0;
    cap_img    = 1'b0;
    cap_ker    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (wr_type == GEMM0_SRAM_IDX) begin
            img_clr = 1'b1;
            img_inc = 1'b1;
            if (wr_last) begin
              cap_img = 1'b1;
              state_d = LOAD_KER;
            end else begin
              state_d = LOAD_IMG;
            end
          end else begin
            err_code_d = ERR_ORDER;
            state_d    = ERR;
          end
        end
      end

      LOAD_IMG: begin
        if (accept) begin
          if (wr_type == GEMM0_SRAM_IDX) begin
            img_inc = 1'b1;
            if (wr_last) begin
              cap_img = 1'b1;
              state_d = LOAD_KER;
            end
          end else begin
            err_code_d = ERR_ORDER;
            state_d    = ERR;
          end
        end
      end

      LOAD_KER: begin
        if (accept) begin
          if (wr_type == GEMM1_SRAM_IDX) begin
            ker_inc = 1'b1;
            if (wr_last) begin
              cap_ker = 1'b1;
              state_d = CHECK;
            end
          end else begin
            err_code_d = ERR_ORDER;
            state_d    = ERR;
          end
        end
      end

      CHECK: begin
        if (img_cnt != img_size) begin
          err_code_d = ERR_IMG_SIZE;
          state_d    = ERR;
        end else if (ker_cnt != ker_size) begin
          err_code_d = ERR_KER_SIZE;
          state_d    = ERR;
        end else if (img_col_q != ker_row_q) begin
          err_code_d = ERR_SHAPE;
          state_d    = ERR;
        end else begin
          state_d = START;
        end
      end

      // compute_done is deliberately not looked at here.
      START: state_d = RUN;

      RUN: begin
        if (compute_done) begin
          state_d = DONE;
`ifdef GEMM_LOAD_TIMEOUT_EN
        end else if (run_limit) begin
          err_code_d = ERR_TIMEOUT;
          state_d    = ERR;
`endif
        end
      end

      DONE: begin
        img_clr = 1'b1;
        ker_clr = 1'b1;
        state_d = IDLE;
      end

      ERR: begin
        if (clear_err) begin
          img_clr    = 1'b1;
          ker_clr    = 1'b1;
          err_code_d = ERR_NONE;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, error code and registered outputs, all derived from the next state
  // so each output is aligned with the state it describes.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state_q         <= IDLE;
      err_code_q      <= ERR_NONE;
      in_ready_q      <= 1'b1;
      compute_start_q <= 1'b0;
      job_done_q      <= 1'b0;
      busy_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      err_code_q      <= err_code_d;
      in_ready_q      <= (state_d == IDLE) || (state_d == LOAD_IMG) || (state_d == LOAD_KER);
      compute_start_q <= (state_d == START);
      job_done_q      <= (state_d == DONE);
      busy_q          <= (state_d != IDLE);
      err_q           <= (state_d == ERR);
    end
  end

  // Segment dimensions, captured on the last element of each segment.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      img_row_q <= '0;
      img_col_q <= '0;
      num_ch_q  <= '0;
      ker_row_q <= '0;
      ker_col_q <= '0;
    end else begin
      if (cap_img) begin
        img_row_q <= img_row;
        img_col_q <= img_col;
        num_ch_q  <= num_channels;
      end
      if (cap_ker) begin
        ker_row_q <= ker_row;
        ker_col_q <= ker_col;
      end
    end
  end

  assign in_ready      = in_ready_q;
  assign compute_start = compute_start_q;
  assign job_done      = job_done_q;
  assign busy          = busy_q;
  assign err           = err_q;
  assign err_code      = err_code_q;

endmodule

// File: tb/tb_gemm_load_sequencer.sv
// Self-checking bench for gemm_load_sequencer: nominal jobs, size/shape/order
// errors, clear_err handling and reset in the middle of a running job.
// Job outcomes are queued when a job is driven and compared when the DUT
// reports job_done or raises err.
module tb_gemm_load_sequencer;
  import npu_pkg::*;

  localparam int AW = 13;
  localparam int CW = 7;

  typedef struct packed {
    logic       err;
    logic [2:0] code;
  } outcome_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid, wr_last, compute_done, clear_err;
  logic [2:0]    wr_type;
  logic [AW-1:0] img_row, img_col, ker_row, ker_col;
  logic [CW-1:0] num_channels;
  logic          in_ready, compute_start, job_done, busy, err;
  logic [2:0]    err_code;

  outcome_t sb_q[$];
  int       n_checks = 0;
  int       n_pass   = 0;

  gemm_load_sequencer dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (rst),
    .wr_valid      (wr_valid),
    .wr_type       (wr_type),
    .wr_last       (wr_last),
    .img_row       (img_row),
    .img_col       (img_col),
    .ker_row       (ker_row),
    .ker_col       (ker_col),
    .num_channels  (num_channels),
    .in_ready      (in_ready),
    .compute_start (compute_start),
    .compute_done  (compute_done),
    .job_done      (job_done),
    .busy          (busy),
    .err           (err),
    .err_code      (err_code),
    .clear_err     (clear_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_outcome(input logic e, input logic [2:0] c);
    outcome_t o;
    o.err  = e;
    o.code = c;
    sb_q.push_back(o);
  endtask

  // Scoreboard monitor: one outcome per job_done pulse or err rising edge.
  initial begin
    logic err_seen;
    outcome_t o;
    err_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        err_seen = 1'b0;
      end else begin
        if (job_done || (err && !err_seen)) begin
          if (sb_q.size() == 0) begin
            check("unexpected_outcome", 32'd1, 32'd0);
          end else begin
            o = sb_q.pop_front();
            check("sb_err", err, o.err);
            check("sb_err_code", err_code, o.code);
          end
        end
        err_seen = err;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  task automatic set_dims(input int ir, input int ic, input int kr, input int kc, input int ch);
    img_row      = AW'(ir);
    img_col      = AW'(ic);
    ker_row      = AW'(kr);
    ker_col      = AW'(kc);
    num_channels = CW'(ch);
  endtask

  task automatic send_seg(input logic [2:0] t, input int n);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_type  = t;
      wr_last  = (i == n - 1);
      step();
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_compute_start", compute_start, 0);
    check("rst_job_done", job_done, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    step();
    step();
    rst = 1'b0;
  endtask

  // Loads both segments and checks the CHECK/START/RUN timing.
  task automatic load_to_start(input int img_n, input int ker_n, input bit done_in_start);
    step();
    send_seg(GEMM0_SRAM_IDX, img_n);
    send_seg(GEMM1_SRAM_IDX, ker_n);
    @(negedge clk);
    check("check_cycle_start", compute_start, 0);
    check("check_cycle_ready", in_ready, 0);
    check("check_cycle_busy", busy, 1);
    @(negedge clk);
    check("start_pulse", compute_start, 1);
    if (done_in_start) compute_done = 1'b1;
    step();
    compute_done = 1'b0;
    @(negedge clk);
    check("start_one_cycle", compute_start, 0);
    check("run_no_job_done", job_done, 0);
    check("run_busy", busy, 1);
  endtask

  task automatic finish_job(input int delay, input bit clr_in_run);
    clear_err = clr_in_run;
    repeat (delay) @(posedge clk);
    #1;
    clear_err    = 1'b0;
    compute_done = 1'b1;
    step();
    compute_done = 1'b0;
    @(negedge clk);
    check("job_done_pulse", job_done, 1);
    check("done_ready_low", in_ready, 0);
    check("done_err_low", err, 0);
    @(negedge clk);
    check("job_done_one_cycle", job_done, 0);
    check("idle_ready", in_ready, 1);
    check("idle_busy", busy, 0);
    check("sb_drained", sb_q.size(), 0);
  endtask

  task automatic run_nominal(input int ir, input int ic, input int kr, input int kc,
                             input int ch, input bit done_in_start, input bit clr_in_run);
    set_dims(ir, ic, kr, kc, ch);
    push_outcome(1'b0, ERR_NONE);
    load_to_start(ir * ic * ch, kr * kc * ch, done_in_start);
    finish_job(10, clr_in_run);
  endtask

  task automatic clear_and_check();
    step();
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    @(negedge clk);
    check("clr_err", err, 0);
    check("clr_err_code", err_code, 0);
    check("clr_ready", in_ready, 1);
    check("clr_busy", busy, 0);
  endtask

  // Job whose CHECK stage must fail with the given code.
  task automatic run_error(input int img_n, input int ker_n, input logic [2:0] code);
    bit start_seen;
    push_outcome(1'b1, code);
    step();
    send_seg(GEMM0_SRAM_IDX, img_n);
    send_seg(GEMM1_SRAM_IDX, ker_n);
    @(negedge clk);
    start_seen = compute_start;
    check("chk_cycle_no_err", err, 0);
    @(negedge clk);
    start_seen = start_seen | compute_start;
    check("err_flag", err, 1);
    check("err_code", err_code, code);
    check("err_ready_low", in_ready, 0);
    @(negedge clk);
    start_seen = start_seen | compute_start;
    check("err_no_start", start_seen, 0);
    check("err_held", err_code, code);
    check("sb_drained", sb_q.size(), 0);
    clear_and_check();
  endtask

  initial begin
    wr_valid     = 1'b0;
    wr_type      = 3'd0;
    wr_last      = 1'b0;
    compute_done = 1'b0;
    clear_err    = 1'b0;
    set_dims(0, 0, 0, 0, 0);
    apply_reset();

    // Nominal 2x3 image, 3x2 kernel, one channel.
    run_nominal(2, 3, 3, 2, 1, 1'b0, 1'b0);
    // Multi-channel job; compute_done in START is ignored, clear_err in RUN too.
    run_nominal(2, 2, 2, 3, 2, 1'b1, 1'b1);
    // Single-element segments: last on the very first element.
    run_nominal(1, 1, 1, 1, 1, 1'b0, 1'b0);

    // Image short by one element.
    set_dims(2, 3, 3, 2, 1);
    run_error(5, 6, ERR_IMG_SIZE);
    // Kernel long by one element.
    run_error(6, 7, ERR_KER_SIZE);
    // Both counts wrong: image error has priority.
    run_error(7, 5, ERR_IMG_SIZE);
    // Inner dimension mismatch with correct counts.
    set_dims(2, 3, 4, 2, 1);
    run_error(6, 8, ERR_SHAPE);

    // Order violation: first element aimed at GEMM1.
    push_outcome(1'b1, ERR_ORDER);
    step();
    wr_valid = 1'b1;
    wr_type  = GEMM1_SRAM_IDX;
    wr_last  = 1'b0;
    step();
    wr_valid = 1'b0;
    @(negedge clk);
    check("order_err", err, 1);
    check("order_code", err_code, ERR_ORDER);
    check("order_ready", in_ready, 0);
    step();
    wr_valid = 1'b1;
    wr_type  = GEMM0_SRAM_IDX;
    wr_last  = 1'b1;
    step();
    step();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    @(negedge clk);
    check("order_ignored_err", err, 1);
    check("order_ignored_code", err_code, ERR_ORDER);
    check("order_ignored_busy", busy, 1);
    clear_and_check();

    // clear_err while idle changes nothing.
    step();
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    @(negedge clk);
    check("idle_clr_busy", busy, 0);
    check("idle_clr_ready", in_ready, 1);

    // Reset three cycles into RUN aborts the job.
    set_dims(2, 3, 3, 2, 1);
    load_to_start(6, 6, 1'b0);
    step();
    step();
    rst = 1'b1;
    #1;
    check("abort_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_start", compute_start, 0);
    check("abort_job_done", job_done, 0);
    check("abort_err", err, 0);
    step();
    rst = 1'b0;
    step();
    compute_done = 1'b1;
    step();
    compute_done = 1'b0;
    @(negedge clk);
    check("stale_done_ignored", job_done, 0);
    check("stale_done_busy", busy, 0);
    run_nominal(2, 3, 3, 2, 1, 1'b0, 1'b0);

    check("sb_final_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gemm_load_sequencer.md
Name: gemm_load_sequencer

Overview:
- Sequences one GEMM job on top of the AXI-stream input stage.
- Tracks the image segment, then the kernel segment, being written into the GEMM0/GEMM1 SRAMs, counting elements per segment.
- Validates element counts against the dimensions delivered in tuser and checks inner-dimension compatibility.
- Pulses compute_start, waits for compute_done and back-pressures the input stage while the job is checked and running.

Parameters:
- ADDR_WIDTH, 13, width of each row/col dimension
- NUM_CHANNELS_WIDTH, 7, width of channel count ($clog2(64+1))
- CNT_WIDTH, 2*ADDR_WIDTH+NUM_CHANNELS_WIDTH, width of element counters and size products
- TIMEOUT_CYCLES, 65536, RUN watchdog limit; used only with the optional feature

Ports:
- s_axis_aclk  in  1  clock
- s_axis_areset  in  1  asynchronous, active-high reset
- wr_valid  in  1  one element written this cycle (input stage write_enable)
- wr_type  in  3  destination SRAM index of that element
- wr_last  in  1  final element of the current segment; coincident with wr_valid
- img_row, img_col  in  ADDR_WIDTH  image dimensions; stable whenever wr_last is high
- ker_row, ker_col  in  ADDR_WIDTH  kernel dimensions; stable whenever wr_last is high
- num_channels  in  NUM_CHANNELS_WIDTH  channel count; stable whenever wr_last is high
- in_ready  out  1  upstream may send data
- compute_start  out  1  one-cycle pulse to the GEMM engine
- compute_done  in  1  one-cycle pulse from the GEMM engine
- job_done  out  1  one-cycle pulse when the job completes
- busy  out  1  state != IDLE
- err  out  1  sticky error flag
- err_code  out  3  cause of the error
- clear_err  in  1  leave ERR

Behaviour:
- Reset, asynchronous: state IDLE, all counters 0, captured dims 0. Outputs: in_ready=1, compute_start=0, job_done=0, busy=0, err=0, err_code=0.
- Reset mid-job aborts immediately; compute_start never glitches.
- Element acceptance: an element is accepted when wr_valid && in_ready. wr_valid while in_ready=0 is ignored.
- in_ready is registered: 1 in IDLE, LOAD_IMG and LOAD_KER; 0 otherwise.
- IDLE:
  - Accepted element with wr_type==GEMM0_SRAM_IDX: img_cnt=1; go to LOAD_IMG, or to LOAD_KER if wr_last (dims captured).
  - Any other wr_type: err_code=5, go to ERR.
- LOAD_IMG:
  - Accepted element: img_cnt++. wr_type must equal GEMM0_SRAM_IDX, else ERR code 5.
  - On wr_last: capture img_row, img_col, num_channels; go to LOAD_KER.
- LOAD_KER: same as LOAD_IMG but with GEMM1_SRAM_IDX and ker_cnt. On wr_last: capture ker_row, ker_col; go to CHECK.
- Counters saturate at all-ones and never wrap.
- CHECK: one cycle; products are formed at CNT_WIDTH bits with no truncation. Checks, highest priority first:
  - img_cnt != img_row*img_col*ch -> code 1
  - ker_cnt != ker_row*ker_col*ch -> code 2
  - img_col != ker_row -> code 3
  - Any failure goes to ERR; otherwise go to START.
- START: compute_start=1 for exactly one cycle; go to RUN. compute_done is ignored in START.
- RUN: on compute_done go to DONE.
- DONE: job_done=1 for one cycle; counters clear; go to IDLE.
- ERR:
  - err=1 and err_code held; in_ready=0.
  - clear_err returns to IDLE, clears err, err_code and counters.
  - clear_err outside ERR has no effect.
- Latency: last kernel element accepted (cycle N) -> CHECK (N+1) -> compute_start high (N+2). compute_done (cycle M) -> job_done high (M+1) -> in_ready high (M+2).
- All outputs are registered.

Optional Feature:
- GEMM_LOAD_TIMEOUT_EN defined:
  - A RUN cycle counter is added.
  - If TIMEOUT_CYCLES elapse with no compute_done: err_code=4, go to ERR.
  - compute_done in the same cycle as the limit wins, i.e. no error.
- Macro undefined: no counter, and RUN waits indefinitely.

Decomposition:
- Shared package npu_pkg holds:
  - GEMM0_SRAM_IDX=3'd0, GEMM1_SRAM_IDX=3'd1
  - state encoding localparams: IDLE, LOAD_IMG, LOAD_KER, CHECK, START, RUN, DONE, ERR
  - error codes: ERR_NONE=0, ERR_IMG_SIZE=1, ERR_KER_SIZE=2, ERR_SHAPE=3, ERR_TIMEOUT=4, ERR_ORDER=5
- One natural sub-module: seg_counter, a saturating CNT_WIDTH counter with clear. Instantiate it twice, for image and kernel.

Test Plan:
- Nominal job:
  - Stimulus: img 2x3, ch 1, 6 GEMM0 writes; ker 3x2, 6 GEMM1 writes.
  - Response: compute_start pulses 2 cycles after the last kernel write. compute_done 10 cycles later -> job_done 1 cycle later, then in_ready=1.
- Image size mismatch:
  - Stimulus: img 2x3 declared, only 5 GEMM0 writes, then a valid kernel.
  - Response: err=1, err_code=1, no compute_start, in_ready=0. clear_err -> IDLE.
- Shape mismatch:
  - Stimulus: img 2x3, ker 4x2, counts correct.
  - Response: err_code=3.
- Order violation:
  - Stimulus: first write has wr_type=1.
  - Response: err_code=5 on the next cycle. Further wr_valid is ignored.
- Reset during RUN:
  - Stimulus: assert s_axis_areset 3 cycles after compute_start.
  - Response: all outputs at reset values immediately. A later compute_done is ignored; a new nominal job succeeds.
- Timeout (GEMM_LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=16):
  - No compute_done -> err_code=4 after 16 RUN cycles.
  - compute_done at cycle 16 -> job_done, no error.
